// File: rtl/vga_timing_pkg.sv
// Raster timing constants for the 640x480 tile display, shared by the
// scanner, its axis counters and the output interface.
package vga_timing_pkg;
  localparam int H_SYNC    = 92;
  localparam int H_BACK    = 50;
  localparam int H_DISP    = 640;
  localparam int H_FRONT   = 18;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_DISP    = 480;
  localparam int V_FRONT   = 10;
  localparam int TILE_BITS = 5;

  localparam int H_LINE      = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_FRAME     = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int H_ACT_START = H_SYNC + H_BACK;
  localparam int V_ACT_START = V_SYNC + V_BACK;
  localparam int COLS        = H_DISP >> TILE_BITS;
  localparam int ROWS        = V_DISP >> TILE_BITS;

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int OFF_W = TILE_BITS;
endpackage

// File: rtl/vga_tile_if.sv
// Registered raster/tile outputs handed to the map/colour stage.
interface vga_tile_if;
  import vga_timing_pkg::*;

  logic             o_VGA_HSync;
  logic             o_VGA_VSync;
  logic             o_Active;
  logic             o_Line_Start;
  logic             o_Frame_Start;
  logic [COL_W-1:0] o_Col;
  logic [ROW_W-1:0] o_Row;
  logic [OFF_W-1:0] o_Px;
  logic [OFF_W-1:0] o_Py;

  modport master (output o_VGA_HSync, o_VGA_VSync, o_Active, o_Line_Start,
                  o_Frame_Start, o_Col, o_Row, o_Px, o_Py);
  modport slave  (input  o_VGA_HSync, o_VGA_VSync, o_Active, o_Line_Start,
                  o_Frame_Start, o_Col, o_Row, o_Px, o_Py);
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus incremental tile index/offset that
// always describe the current count value (no division downstream).
module vga_axis_counter #(
  parameter  int SYNC      = 92,
  parameter  int BACK      = 50,
  parameter  int DISP      = 640,
  parameter  int FRONT     = 18,
  parameter  int TILE_BITS = 5,
  parameter  int IDX_W     = 5,
  localparam int TOTAL     = SYNC + BACK + DISP + FRONT,
  localparam int CNT_W     = $clog2(TOTAL)
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_Step,
  output logic [CNT_W-1:0]     count,
  output logic                 wrap,
  output logic                 sync_n,
  output logic                 active,
  output logic [IDX_W-1:0]     tile,
  output logic [TILE_BITS-1:0] offset
);
  localparam int ACT_START = SYNC + BACK;
  localparam int ACT_END   = ACT_START + DISP - 1;
  localparam int TILE_MAX  = (DISP >> TILE_BITS) - 1;

  logic [CNT_W-1:0] cnt_nxt;
  logic             act_nxt;

  assign wrap    = i_Step && (count == CNT_W'(TOTAL - 1));
  assign cnt_nxt = wrap ? '0 : count + 1'b1;
  assign act_nxt = (cnt_nxt >= CNT_W'(ACT_START)) && (cnt_nxt <= CNT_W'(ACT_END));
  assign sync_n  = (count >= CNT_W'(SYNC));
  assign active  = (count >= CNT_W'(ACT_START)) && (count <= CNT_W'(ACT_END));

  // Tile state is advanced together with the counter so it tracks cnt_nxt.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count  <= '0;
      tile   <= '0;
      offset <= '0;
    end else if (i_Step) begin
      count <= cnt_nxt;
      if (!act_nxt || cnt_nxt == CNT_W'(ACT_START)) begin
        tile   <= '0;
        offset <= '0;
      end else begin
        offset <= offset + 1'b1;
        if (&offset && tile != IDX_W'(TILE_MAX)) tile <= tile + 1'b1;
      end
    end
  end
endmodule

// File: rtl/vga_tile_scanner.sv
// Raster timing and tile-coordinate generator; all outputs registered one
// clock behind the counter position they describe.
module vga_tile_scanner import vga_timing_pkg::*; #(
  parameter int HS = H_SYNC,
  parameter int HB = H_BACK,
  parameter int HD = H_DISP,
  parameter int HF = H_FRONT,
  parameter int VS = V_SYNC,
  parameter int VB = V_BACK,
  parameter int VD = V_DISP,
  parameter int VF = V_FRONT
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  vga_tile_if.master  vid
);
  localparam int H_CW = $clog2(HS + HB + HD + HF);
  localparam int V_CW = $clog2(VS + VB + VD + VF);

  logic [H_CW-1:0]  h_cnt;
  logic [V_CW-1:0]  v_cnt;
  logic             h_wrap, v_wrap_unused;
  logic             h_sync_n, v_sync_n, h_act, v_act;
  logic [COL_W-1:0] h_tile;
  logic [ROW_W-1:0] v_tile;
  logic [OFF_W-1:0] h_off, v_off;
  logic             h_at_start;

  vga_axis_counter #(.SYNC(HS), .BACK(HB), .DISP(HD), .FRONT(HF),
                     .TILE_BITS(TILE_BITS), .IDX_W(COL_W)) u_h (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Step(1'b1),
    .count(h_cnt), .wrap(h_wrap), .sync_n(h_sync_n), .active(h_act),
    .tile(h_tile), .offset(h_off)
  );

  vga_axis_counter #(.SYNC(VS), .BACK(VB), .DISP(VD), .FRONT(VF),
                     .TILE_BITS(TILE_BITS), .IDX_W(ROW_W)) u_v (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Step(h_wrap),
    .count(v_cnt), .wrap(v_wrap_unused), .sync_n(v_sync_n), .active(v_act),
    .tile(v_tile), .offset(v_off)
  );

  assign h_at_start = (h_cnt == H_CW'(HS + HB));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      vid.o_VGA_HSync   <= 1'b1;
      vid.o_VGA_VSync   <= 1'b1;
      vid.o_Active      <= 1'b0;
      vid.o_Line_Start  <= 1'b0;
      vid.o_Frame_Start <= 1'b0;
      vid.o_Col         <= '0;
      vid.o_Row         <= '0;
      vid.o_Px          <= '0;
      vid.o_Py          <= '0;
    end else begin
      vid.o_VGA_HSync   <= h_sync_n;
      vid.o_VGA_VSync   <= v_sync_n;
      vid.o_Active      <= h_act && v_act;
      vid.o_Line_Start  <= h_at_start && v_act;
      vid.o_Frame_Start <= h_at_start && (v_cnt == V_CW'(VS + VB));
      vid.o_Col         <= h_tile;
      vid.o_Row         <= v_tile;
      vid.o_Px          <= h_off;
      vid.o_Py          <= v_off;
    end
  end
endmodule

// File: tb/tb_vga_tile_scanner.sv
// Checks a full-size scanner and a reduced-geometry one against a raster
// model that derives every output from the position index by division.
module tb_vga_tile_scanner;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic       hs, vs, act, ls, fs;
    logic [4:0] col;
    logic [3:0] row;
    logic [4:0] px, py;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pos;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vga_tile_if if_full ();
  vga_tile_if if_small ();

  vga_tile_scanner u_full (.i_Clk(clk), .i_Rst_n(rst_n), .vid(if_full));
  vga_tile_scanner #(.HS(4), .HB(3), .HD(64), .HF(2),
                     .VS(2), .VB(3), .VD(64), .VF(2)) u_small (
    .i_Clk(clk), .i_Rst_n(rst_n), .vid(if_small));

  obs_t of_full, of_small;
  assign of_full  = {if_full.o_VGA_HSync, if_full.o_VGA_VSync, if_full.o_Active,
                     if_full.o_Line_Start, if_full.o_Frame_Start, if_full.o_Col,
                     if_full.o_Row, if_full.o_Px, if_full.o_Py};
  assign of_small = {if_small.o_VGA_HSync, if_small.o_VGA_VSync, if_small.o_Active,
                     if_small.o_Line_Start, if_small.o_Frame_Start, if_small.o_Col,
                     if_small.o_Row, if_small.o_Px, if_small.o_Py};

  // Number of clock edges since reset release; outputs show position pos-1.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pos <= 0;
    else        pos <= pos + 1;

  function automatic obs_t model(int h_s, int h_b, int h_d, int h_f,
                                 int v_s, int v_b, int v_d, int v_f, int p_idx);
    obs_t e;
    int hl, vl, p, h, v;
    bit ha, va;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (p_idx == 0) return e;
    hl = h_s + h_b + h_d + h_f;
    vl = v_s + v_b + v_d + v_f;
    p  = p_idx - 1;
    h  = p % hl;
    v  = (p / hl) % vl;
    ha = (h >= h_s + h_b) && (h < h_s + h_b + h_d);
    va = (v >= v_s + v_b) && (v < v_s + v_b + v_d);
    e.hs  = !(h < h_s);
    e.vs  = !(v < v_s);
    e.act = ha && va;
    e.ls  = va && (h == h_s + h_b);
    e.fs  = e.ls && (v == v_s + v_b);
    if (ha) begin
      e.col = 5'((h - h_s - h_b) / 32);
      e.px  = 5'((h - h_s - h_b) % 32);
    end
    if (va) begin
      e.row = 4'((v - v_s - v_b) / 32);
      e.py  = 5'((v - v_s - v_b) % 32);
    end
    return e;
  endfunction

  task automatic chk_obs(string name, obs_t got, obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s pos=%0d: got hs=%b vs=%b act=%b ls=%b fs=%b col=%0d row=%0d px=%0d py=%0d, expected hs=%b vs=%b act=%b ls=%b fs=%b col=%0d row=%0d px=%0d py=%0d",
               name, pos, got.hs, got.vs, got.act, got.ls, got.fs, got.col, got.row, got.px, got.py,
               exp.hs, exp.vs, exp.act, exp.ls, exp.fs, exp.col, exp.row, exp.px, exp.py);
    end
  endtask

  task automatic chk_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  int   phase = 0;
  logic prev_hs = 1'b1;
  int   hs_low = 0, vs_low = 0, fs_cnt = 0, fs_first = 0, fs2 = 0;
  int   line_act = 0, last_col = -1, last_px = -1;
  int   sm_ls = 0, sm_col = -1, sm_row = -1, sm_px = -1, sm_py = -1;
  int   hs_falls[$];
  int   sm_fs[$];

  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_obs("full",  of_full,  model(H_SYNC, H_BACK, H_DISP, H_FRONT,
                                       V_SYNC, V_BACK, V_DISP, V_FRONT, pos));
      chk_obs("small", of_small, model(4, 3, 64, 2, 2, 3, 64, 2, pos));
      if (phase == 1) begin
        if (pos >= 1 && pos <= 800 && !of_full.hs) hs_low++;
        if (prev_hs && !of_full.hs) hs_falls.push_back(pos);
        if (!of_full.vs) vs_low++;
        if (of_full.fs) begin
          fs_cnt++;
          if (fs_first == 0) fs_first = pos;
        end
        if (pos >= 28143 && pos < 28943 && of_full.act) begin
          line_act++;
          last_col = int'(of_full.col);
          last_px  = int'(of_full.px);
        end
        if (of_small.fs) sm_fs.push_back(pos);
        if (pos >= 1 && pos <= 5183) begin
          if (of_small.ls) sm_ls++;
          if (of_small.act) begin
            sm_col = int'(of_small.col);
            sm_row = int'(of_small.row);
            sm_px  = int'(of_small.px);
            sm_py  = int'(of_small.py);
          end
        end
      end else if (phase == 2 && of_full.fs && fs2 == 0) begin
        fs2 = pos;
      end
      prev_hs = of_full.hs;
    end
  endtask

  initial begin
    tick(10);
    chk_int("rst_hsync",  int'(if_full.o_VGA_HSync), 1);
    chk_int("rst_vsync",  int'(if_full.o_VGA_VSync), 1);
    chk_int("rst_active", int'(if_full.o_Active), 0);
    chk_int("rst_coords", int'({if_full.o_Col, if_full.o_Row, if_full.o_Px, if_full.o_Py}), 0);

    #1 rst_n = 1'b1;
    phase = 1;
    tick(1);
    chk_int("hsync_first_low", int'(if_full.o_VGA_HSync), 0);
    tick(30999);

    chk_int("hsync_low_len", hs_low, 92);
    chk_int("hsync_period", hs_falls.size() >= 2 ? hs_falls[1] - hs_falls[0] : -1, 800);
    chk_int("vsync_low_len", vs_low, 1600);
    chk_int("frame_start_pos", fs_first, 28143);
    chk_int("frame_start_width", fs_cnt, 1);
    chk_int("line35_active", line_act, 640);
    chk_int("line35_last_col", last_col, 19);
    chk_int("line35_last_px", last_px, 31);
    chk_int("small_fs_first", sm_fs.size() >= 1 ? sm_fs[0] : -1, 373);
    chk_int("small_fs_spacing", sm_fs.size() >= 2 ? sm_fs[1] - sm_fs[0] : -1, 5183);
    chk_int("small_line_starts", sm_ls, 64);
    chk_int("small_last_col", sm_col, 1);
    chk_int("small_last_px", sm_px, 31);
    chk_int("small_last_row", sm_row, 1);
    chk_int("small_last_py", sm_py, 31);

    // Mid-line reset away from any clock edge: outputs must clear at once.
    phase = 0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_int("async_active", int'(if_full.o_Active), 0);
    chk_int("async_col", int'(if_full.o_Col), 0);
    chk_int("async_px", int'(if_full.o_Px), 0);
    chk_int("async_hsync", int'(if_full.o_VGA_HSync), 1);
    tick(3);
    #1 rst_n = 1'b1;
    phase = 2;
    tick(28150);
    chk_int("restart_frame_start", fs2, 142 + 35 * 800 + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
